bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: HOLD_LIMIT, default 16, maximum consecutive grant cycles before a forced rotation (used only when the configuration macro is defined); legal range 2..255.
REQ-002 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: m0_req_  input  1  master 0 bus request, active low.
REQ-005 Port: m1_req_  input  1  master 1 bus request, active low.
REQ-006 Port: m2_req_  input  1  master 2 bus request, active low.
REQ-007 Port: m3_req_  input  1  master 3 bus request, active low.
REQ-008 Port: m0_grnt_ / m1_grnt_ / m2_grnt_ / m3_grnt_  output  1 each  bus grant to master 0..3, active low, registered; these drive the grant inputs of the bus master multiplexer.
REQ-009 Port: owner  output  2  index of the master currently holding the grant, registered.
REQ-010 Port: hold_cnt  output  8  consecutive cycles the current owner has held the grant, registered, saturating at 255.

Function
REQ-011 Exactly one grant output is low in every cycle after reset; the grant is never removed, so the bus is always parked on one master.
REQ-012 The grant outputs are the one-hot-low decode of owner: owner=n drives mn_grnt_ low and the other three high.
REQ-013 The arbiter uses two states. OWNED: the owner is asserting its request. PARKED: the owner's request is high.
REQ-014 In OWNED, owner is unchanged while the owner's request stays low. Exception: REQ-024.
REQ-015 In PARKED, owner moves at the next rising edge to the first requesting master in round-robin order owner+1, owner+2, owner+3 (mod 4).
REQ-016 In PARKED with no master requesting, owner is unchanged (parking).
REQ-017 Grant latency: a request presented at edge k to an idle, parked bus drives that master's grant low after edge k+1 (one cycle).
REQ-018 Handover: the owner releases its request at edge k while others are waiting; the new grant is valid after edge k+1, with no cycle in which zero or two grants are low.
REQ-019 If the parked owner re-requests in the same cycle that another master requests, the other master wins; the parked owner is searched last (offset 4).
REQ-020 hold_cnt clears to 0 on every change of owner and increments once per cycle otherwise.
REQ-021 Simultaneous requests from all four masters, each holding for one transfer, are served in strict order owner+1, +2, +3, +0.

Reset
REQ-022 When reset is high at a rising edge: owner=2'd0; m0_grnt_=0; m1_grnt_, m2_grnt_, m3_grnt_=1; hold_cnt=0; state=PARKED.
REQ-023 Reset overrides all request activity in the same cycle, including a reset asserted mid-ownership. The grant returns to master 0 one edge later, whatever the owner was before.

Configuration
REQ-024 With macro BUS_ARB_HOLD_LIMIT_EN defined: in OWNED, when hold_cnt equals HOLD_LIMIT-1 and at least one other master is requesting, owner moves at the next edge as in REQ-015, even though the owner's request is still low. If no other master is requesting, there is no rotation and hold_cnt keeps counting.
REQ-025 Without BUS_ARB_HOLD_LIMIT_EN: an owner keeps the bus for as long as its request stays low; HOLD_LIMIT is ignored; hold_cnt is still produced.

Verification
REQ-026 Scenario: hold reset 2 cycles, then release it with all requests high -> m0_grnt_=0, owner=0, hold_cnt counts 1,2,3...
REQ-027 Scenario: from reset, hold m2_req_ low -> after 1 edge owner=2 and m2_grnt_=0; after 5 more cycles hold_cnt=5.
REQ-028 Scenario: owner=0 with requests 1, 2, 3 all low; each new owner drops its request 3 cycles after being granted -> grant sequence 1, 2, 3; never zero or two grants low.
REQ-029 Scenario: owner=3 releases while m0_req_ and m3_req_ are both low in the same cycle -> owner=0.
REQ-030 Scenario: with BUS_ARB_HOLD_LIMIT_EN and HOLD_LIMIT=4, master 1 holds its request indefinitely and master 2 requests -> owner changes 1->2 exactly 4 cycles after master 1's grant; without the macro, owner stays 1.
REQ-031 Scenario: reset pulsed for 1 cycle while owner=3 with m3_req_ low -> next cycle owner=0 and hold_cnt=0; the edge after that, owner=3.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: four-master round-robin bus arbiter with bus parking.
//
// Requests and grants are active low. Exactly one grant is low in every cycle
// after reset, so the bus is always parked on some master. The FSM has two
// states:
//   OWNED  - the owner asserted its request, so it keeps the bus while the
//            request stays low.
//   PARKED - the owner dropped its request. The grant stays with the owner
//            until another master asks. A re-request by the parked owner
//            ranks behind every other requester.
//
// Optional feature: define BUS_ARB_HOLD_LIMIT_EN to force a rotation. The
// rotation happens after the owner has held the bus for HOLD_LIMIT
// consecutive cycles while another master is waiting. Without the macro,
// HOLD_LIMIT has no effect and an owner keeps the bus for as long as it
// requests.

module bus_arbiter #(
    parameter int HOLD_LIMIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m0_req_,
    input  logic       m1_req_,
    input  logic       m2_req_,
    input  logic       m3_req_,
    output logic       m0_grnt_,
    output logic       m1_grnt_,
    output logic       m2_grnt_,
    output logic       m3_grnt_,
    output logic [1:0] owner,
    output logic [7:0] hold_cnt
);

    typedef enum logic [0:0] {
        ST_PARKED = 1'b0,
        ST_OWNED  = 1'b1
    } arb_state_t;

`ifdef BUS_ARB_HOLD_LIMIT_EN
    localparam logic LIMIT_EN = 1'b1;
`else
    localparam logic LIMIT_EN = 1'b0;
`endif

    // hold_cnt value seen on the last cycle an owner may keep the bus while
    // another master is waiting.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_LIMIT - 1);

    // Round-robin search over owner+1, owner+2, owner+3.
    // Returns {found, index}. The owner itself is not searched here. A parked
    // owner that requests again is handled by the caller, so it always loses
    // to any other requester.
    function automatic logic [2:0] rr_next(input logic [1:0] base,
                                           input logic [3:0] req);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 1; k <= 3; k++) begin
            idx = base + 2'(k);
            res = (!res[2] && req[idx]) ? {1'b1, idx} : res;
        end
        return res;
    endfunction

    // One-hot-low decode of an owner index onto the four grant lines.
    function automatic logic [3:0] grant_decode(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    arb_state_t state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [7:0] hold_q,  hold_d;
    logic [3:0] grnt_q,  grnt_d;

    logic [3:0] req_act;      // active-high request vector, bit n = master n
    logic [3:0] other_req;    // requests from everyone except the owner
    logic       own_req;
    logic [2:0] pick;         // {found, index} from the round-robin search
    logic       limit_hit;

    // Translate the active-low request pins into an active-high vector and
    // work out what the current owner and the other masters are doing.
    always_comb begin
        req_act   = ~{m3_req_, m2_req_, m1_req_, m0_req_};
        own_req   = req_act[owner_q];
        other_req = req_act & ~(4'b0001 << owner_q);
        pick      = rr_next(owner_q, other_req);
        limit_hit = LIMIT_EN && (hold_q == HOLD_LAST) && (|other_req);
    end

    // Next-state logic: choose the next owner and arbitration state, then
    // derive the counter and grant values that go with that owner.
    always_comb begin
        owner_d = owner_q;
        state_d = state_q;
        case (state_q)
            ST_OWNED: begin
                if (!own_req) begin
                    // The owner released the bus. Hand it to the next
                    // requester, or park on the owner if nobody is asking.
                    if (pick[2]) begin
                        owner_d = pick[1:0];
                        state_d = ST_OWNED;
                    end else begin
                        state_d = ST_PARKED;
                    end
                end else if (limit_hit) begin
                    // Forced rotation. limit_hit already implies that
                    // another master is requesting, so pick is valid.
                    owner_d = pick[1:0];
                    state_d = ST_OWNED;
                end else begin
                    state_d = ST_OWNED;
                end
            end
            ST_PARKED: begin
                if (pick[2]) begin
                    owner_d = pick[1:0];
                    state_d = ST_OWNED;
                end else if (own_req) begin
                    state_d = ST_OWNED;
                end else begin
                    state_d = ST_PARKED;
                end
            end
            default: begin
                owner_d = owner_q;
                state_d = ST_PARKED;
            end
        endcase

        if (owner_d != owner_q) begin
            hold_d = 8'd0;
        end else if (hold_q == 8'd255) begin
            hold_d = 8'd255;
        end else begin
            hold_d = hold_q + 8'd1;
        end

        grnt_d = grant_decode(owner_d);
    end

    // State, owner, hold counter and grant registers. Reset parks the bus on
    // master 0 and overrides any request activity in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_PARKED;
            owner_q <= 2'd0;
            hold_q  <= 8'd0;
            grnt_q  <= 4'b1110;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
            grnt_q  <= grnt_d;
        end
    end

    assign m0_grnt_ = grnt_q[0];
    assign m1_grnt_ = grnt_q[1];
    assign m2_grnt_ = grnt_q[2];
    assign m3_grnt_ = grnt_q[3];
    assign owner    = owner_q;
    assign hold_cnt = hold_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter (instantiated with HOLD_LIMIT = 4).
// The expectations for the forced-rotation case follow BUS_ARB_HOLD_LIMIT_EN.
// Inputs change 1 time unit after a rising edge. Outputs are checked at that
// same point, so each tick() corresponds to exactly one arbitration edge.

module tb_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       m0_req_, m1_req_, m2_req_, m3_req_;
    logic       m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
    logic [1:0] owner;
    logic [7:0] hold_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    bus_arbiter #(.HOLD_LIMIT(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .m0_req_  (m0_req_),
        .m1_req_  (m1_req_),
        .m2_req_  (m2_req_),
        .m3_req_  (m3_req_),
        .m0_grnt_ (m0_grnt_),
        .m1_grnt_ (m1_grnt_),
        .m2_grnt_ (m2_grnt_),
        .m3_grnt_ (m3_grnt_),
        .owner    (owner),
        .hold_cnt (hold_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // r_n is active low, with bit n driving master n's request.
    task automatic set_req(input logic [3:0] r_n);
        {m3_req_, m2_req_, m1_req_, m0_req_} = r_n;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] exp_owner,
                             input logic [7:0] exp_hold);
        logic [3:0] exp_g;
        exp_g = ~(4'b0001 << exp_owner);
        check({tag, ".owner"}, {6'd0, owner}, {6'd0, exp_owner});
        check({tag, ".grnt"}, {4'd0, m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_}, {4'd0, exp_g});
        check({tag, ".hold"}, hold_cnt, exp_hold);
    endtask

    // After reset, exactly one grant must be low in every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            n_checks++;
            assert ($countones({m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_}) === 3) else begin
                n_fail++;
                $error("FAIL onehot: observed grants %b expected exactly one low",
                       {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_});
            end
        end
    end

    initial begin
        reset = 1'b1;
        set_req(4'b1111);

        // Reset held for two cycles, then released with no requests:
        // the bus parks on master 0 and hold_cnt counts up.
        tick(); tick();
        check_all("reset", 2'd0, 8'd0);
        mon_en = 1'b1;
        reset  = 1'b0;
        tick(); check_all("park1", 2'd0, 8'd1);
        tick(); check_all("park2", 2'd0, 8'd2);
        tick(); check_all("park3", 2'd0, 8'd3);

        // A request on an idle bus is granted after one cycle.
        reset = 1'b1; tick(); reset = 1'b0;
        set_req(4'b1011);
        tick(); check_all("m2_grant", 2'd2, 8'd0);
        repeat (5) tick();
        check_all("m2_hold5", 2'd2, 8'd5);

        // Handover chain 1 -> 2 -> 3. Each owner drops its request
        // three cycles after being granted.
        reset = 1'b1; set_req(4'b1111); tick(); reset = 1'b0;
        set_req(4'b0001);
        tick(); check_all("chain_m1", 2'd1, 8'd0);
        tick(); tick(); check_all("chain_m1_h2", 2'd1, 8'd2);
        set_req(4'b0011);
        tick(); check_all("chain_m2", 2'd2, 8'd0);
        tick(); tick();
        set_req(4'b0111);
        tick(); check_all("chain_m3", 2'd3, 8'd0);
        tick(); tick();
        set_req(4'b1111);
        tick(); check_all("m3_parked", 2'd3, 8'd3);

        // The parked owner re-requests together with master 0:
        // master 0 wins.
        set_req(4'b0110);
        tick(); check_all("reqst_m0_wins", 2'd0, 8'd0);
        tick(); check_all("m0_keeps", 2'd0, 8'd1);
        // Master 0 releases while master 3 is waiting.
        set_req(4'b0111);
        tick(); check_all("handover_m3", 2'd3, 8'd0);

        // hold_cnt saturates at 255 while no other master is asking.
        repeat (260) tick();
        check_all("hold_sat", 2'd3, 8'd255);
        set_req(4'b1111);
        tick(); check_all("sat_parked", 2'd3, 8'd255);

        // All four masters request together, one transfer each:
        // order 0, 1, 2, 3.
        set_req(4'b0000);
        tick(); check_all("all_first", 2'd0, 8'd0);
        set_req(4'b0001);
        tick(); check_all("all_second", 2'd1, 8'd0);
        set_req(4'b0011);
        tick(); check_all("all_third", 2'd2, 8'd0);
        set_req(4'b0111);
        tick(); check_all("all_fourth", 2'd3, 8'd0);
        tick(); check_all("all_m3_hold", 2'd3, 8'd1);

        // Master 1 holds its request while master 2 waits. With HOLD_LIMIT=4
        // and the feature enabled, the bus rotates 4 cycles after the grant.
        reset = 1'b1; set_req(4'b1111); tick(); reset = 1'b0;
        set_req(4'b1101);
        tick(); check_all("lim_grant", 2'd1, 8'd0);
        set_req(4'b1001);
        tick(); check_all("lim_c1", 2'd1, 8'd1);
        tick(); check_all("lim_c2", 2'd1, 8'd2);
        tick(); check_all("lim_c3", 2'd1, 8'd3);
        tick();
`ifdef BUS_ARB_HOLD_LIMIT_EN
        check_all("lim_c4", 2'd2, 8'd0);
`else
        check_all("lim_c4", 2'd1, 8'd4);
`endif

        // Reset pulsed mid-ownership while master 3 keeps requesting.
        reset = 1'b1; set_req(4'b1111); tick(); reset = 1'b0;
        set_req(4'b0111);
        tick(); check_all("rst_pre_m3", 2'd3, 8'd0);
        tick(); check_all("rst_pre_m3_h1", 2'd3, 8'd1);
        reset = 1'b1;
        tick(); check_all("rst_mid", 2'd0, 8'd0);
        reset = 1'b0;
        tick(); check_all("rst_after", 2'd3, 8'd0);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
